// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch stage, instruction memory and decode.
// Handshakes: a request is accepted on a cycle where imem_req & imem_ready are both
// high. Exactly one imem_rvalid follows each accepted request, at least one cycle later.
// Decode sees valid_d and consumes on any cycle with ~stall_d & ~flush_d & ~redirect_valid.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  logic        stall_d;
  logic        flush_d;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic        valid_d;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;

  logic [1:0]  fsm_state;

  modport master (
    output imem_req, imem_addr, valid_d, instr_d, pc_d, pc_plus4_d, fsm_state,
    input  imem_ready, imem_rvalid, imem_rdata, stall_d, flush_d, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, valid_d, instr_d, pc_d, pc_plus4_d, fsm_state,
    output imem_ready, imem_rvalid, imem_rdata, stall_d, flush_d, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one memory request at a time and
// queues returned words in a small FIFO for decode; honours stall, flush and redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]    state;
  logic [31:0]   fetch_pc;
  logic [31:0]   req_pc;
  logic          outstanding;

  logic [31:0]   buf_instr [DEPTH];
  logic [31:0]   buf_pc    [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic          issue_ok;
  logic          accept;
  logic          push;
  logic          pop;
  logic          clear;
  logic          valid;

  // Counting the in-flight word guarantees the FIFO always has room for it.
  assign issue_ok = (count + CW'(outstanding)) < CW'(DEPTH);
  assign accept   = bus.imem_req & bus.imem_ready;
  assign push     = bus.imem_rvalid & (state == S_WAIT) & ~bus.redirect_valid;
  assign clear    = bus.redirect_valid | bus.flush_d;
  assign valid    = (count != '0);
  assign pop      = valid & ~bus.stall_d & ~clear;

  assign bus.imem_req   = ~rst & (state == S_REQ) & issue_ok;
  assign bus.imem_addr  = fetch_pc;
  assign bus.fsm_state  = state;

  assign bus.valid_d    = valid;
  assign bus.instr_d    = valid ? buf_instr[head] : 32'd0;
  assign bus.pc_d       = valid ? buf_pc[head] : 32'd0;
  assign bus.pc_plus4_d = valid ? (buf_pc[head] + 32'd4) : 32'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_REQ;
      fetch_pc    <= RESET_PC;
      req_pc      <= RESET_PC;
      outstanding <= 1'b0;
    end else begin
      if (bus.redirect_valid) begin
        fetch_pc <= bus.redirect_pc & ~32'h3;
      end
      case (state)
        S_REQ: begin
          if (accept) begin
            req_pc      <= fetch_pc;
            outstanding <= 1'b1;
            state       <= bus.redirect_valid ? S_DROP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.imem_rvalid) begin
            outstanding <= 1'b0;
            state       <= S_REQ;
            if (!bus.redirect_valid) begin
              fetch_pc <= req_pc + 32'd4;
            end
          end else if (bus.redirect_valid) begin
            state <= S_DROP;
          end
        end
        S_DROP: begin
          if (bus.imem_rvalid) begin
            outstanding <= 1'b0;
            state       <= S_REQ;
          end
        end
        default: begin
          outstanding <= 1'b0;
          state       <= S_REQ;
        end
      endcase
    end
  end

  // A word landing in the same cycle as a flush survives as the sole entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clear) begin
      head <= tail;
      if (push) begin
        tail  <= tail + PW'(1);
        count <= CW'(1);
      end else begin
        count <= '0;
      end
    end else begin
      if (push) begin
        tail <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      buf_instr[tail] <= bus.imem_rdata;
      buf_pc[tail]    <= req_pc;
    end
  end

  no_push_when_full: assert property (
    @(posedge clk) disable iff (rst) (push && !clear) |-> (count != CW'(DEPTH))
  );

endmodule
